fetch_unit: RTL and testbench

Instruction fetch stage of the 10-bit CPU. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into a one-entry instruction register. It offers that register to decode over a valid/ready handshake. Unconditional JUMP and HALT are resolved locally; taken conditional branches are redirected from execute.

---
 rtl/isa_pkg.sv | 37 +++
 rtl/fetch_next_pc.sv | 44 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 10-bit CPU: widths, opcode encodings,
// instruction field positions and the fetch-stage state encoding.
package isa_pkg;

    localparam int INSTR_W = 10;
    localparam int ADDR_W  = 10;

    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int JT_MSB = 5;
    localparam int JT_LSB = 0;

    typedef logic [OP_MSB-OP_LSB:0] opcode_t;

    localparam opcode_t OP_HALT  = 4'b0000;
    localparam opcode_t OP_SET   = 4'b0001;
    localparam opcode_t OP_STORE = 4'b0010;
    localparam opcode_t OP_SUB   = 4'b0011;
    localparam opcode_t OP_MUL   = 4'b0100;
    localparam opcode_t OP_BEQ   = 4'b1000;
    localparam opcode_t OP_JUMP  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] jump_target_of(input logic [INSTR_W-1:0] instr);
        return ADDR_W'(instr[JT_MSB:JT_LSB]);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage: redirect, JUMP,
// HALT hold, sequential increment, all reduced modulo the memory depth.
import isa_pkg::*;

module fetch_next_pc #(
    parameter int MEM_DEPTH = 64
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               halt_fetched
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] m;
        m = {1'b0, a} % DEPTH;
        return m[ADDR_W-1:0];
    endfunction

    opcode_t opcode;

    always_comb begin
        opcode       = opcode_of(instruction);
        halt_fetched = (opcode == OP_HALT);
        next_pc      = pc;
        if (redirect) begin
            next_pc = wrap_addr(redirect_target);
        end else if (fetch_en) begin
            if (opcode == OP_JUMP) begin
                next_pc = wrap_addr(jump_target_of(instruction));
            end else if (opcode == OP_HALT) begin
                next_pc = pc;
            end else begin
                next_pc = wrap_addr(pc + ADDR_W'(1));
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the memory word into a
// one-entry IR offered to decode over valid/ready; resolves JUMP/HALT locally.
import isa_pkg::*;

module fetch_unit #(
    parameter int RESET_PC  = 0,
    parameter int MEM_DEPTH = 64
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RUN,
    output logic [ADDR_W-1:0]  ADDRESS,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    output logic [INSTR_W-1:0] IR_OUT,
    output logic [ADDR_W-1:0]  PC_OUT,
    output logic               IR_VALID,
    input  logic               IR_READY,
    input  logic               BRANCH_TAKEN,
    input  logic [ADDR_W-1:0]  BRANCH_TARGET,
    output logic               HALTED
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC % MEM_DEPTH);

    fetch_state_t       state_p0;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc_p0;
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] ir_p1;
    logic [ADDR_W-1:0]  ir_pc_p1;
    logic               vld_p1;
    logic               fetch_en;
    logic               redirect;
    logic               halt_fetched;

    always_comb begin
        fetch_en = (state_p0 == ST_FETCH) && (!vld_p1 || IR_READY);
        redirect = BRANCH_TAKEN && (state_p0 != ST_IDLE);
    end

    fetch_next_pc #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_next_pc (
        .pc              (pc_p0),
        .instruction     (INSTRUCTION),
        .fetch_en        (fetch_en),
        .redirect        (redirect),
        .redirect_target (BRANCH_TARGET),
        .next_pc         (next_pc),
        .halt_fetched    (halt_fetched)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_p0 <= ST_IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // A HALT captured behind an unresolved branch is speculative, so a
    // redirect always returns the FSM to FETCH.
    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_IDLE: begin
                if (RUN) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect)                      state_nxt = ST_FETCH;
                else if (fetch_en && halt_fetched) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (redirect) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: program counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_p0 <= PC_INIT;
        end else begin
            pc_p0 <= next_pc;
        end
    end

    // Stage p1: instruction register toward decode
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_p1    <= '0;
            ir_pc_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (redirect) begin
            vld_p1 <= 1'b0;
        end else if (fetch_en) begin
            ir_p1    <= INSTRUCTION;
            ir_pc_p1 <= pc_p0;
            vld_p1   <= 1'b1;
        end else if (IR_READY) begin
            vld_p1 <= 1'b0;
        end
    end

    assign ADDRESS  = pc_p0;
    assign IR_OUT   = ir_p1;
    assign PC_OUT   = ir_pc_p1;
    assign IR_VALID = vld_p1;
    assign HALTED   = (state_p0 == ST_HALT) && !vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IR deliveries are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       RUN;
    logic [9:0] ADDRESS;
    logic [9:0] INSTRUCTION;
    logic [9:0] IR_OUT;
    logic [9:0] PC_OUT;
    logic       IR_VALID;
    logic       IR_READY;
    logic       BRANCH_TAKEN;
    logic [9:0] BRANCH_TARGET;
    logic       HALTED;

    logic [9:0] mem [64];

    typedef struct packed {
        logic [9:0] pc;
        logic [9:0] ir;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    int   checks;
    int   errors;

    always #5 CLK = ~CLK;

    always_comb INSTRUCTION = mem[ADDRESS[5:0]];

    fetch_unit #(
        .RESET_PC (0),
        .MEM_DEPTH(64)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .RUN          (RUN),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .IR_OUT       (IR_OUT),
        .PC_OUT       (PC_OUT),
        .IR_VALID     (IR_VALID),
        .IR_READY     (IR_READY),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .HALTED       (HALTED)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int pc);
        txn_t t;
        t.pc = 10'(pc);
        t.ir = mem[pc];
        exp_q.push_back(t);
    endtask

    task automatic default_mem();
        for (int i = 0; i < 64; i++) mem[i] = {4'b0010, 6'(i)};
    endtask

    task automatic release_and_run();
        tick();
        RST_N = 1'b1;
        tick();
        RUN = 1'b1;
        tick();
        RUN = 1'b0;
    endtask

    // Monitor: one delivered instruction per accepted handshake, outside redirects.
    always @(negedge CLK) begin
        if (RST_N && IR_VALID && IR_READY && !BRANCH_TAKEN) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %0d ir %b, expected no delivery", PC_OUT, IR_OUT);
            end else begin
                mon_t = exp_q.pop_front();
                if ({PC_OUT, IR_OUT} !== {mon_t.pc, mon_t.ir}) begin
                    errors++;
                    $display("FAIL sb_deliver: got pc %0d ir %b expected pc %0d ir %b",
                             PC_OUT, IR_OUT, mon_t.pc, mon_t.ir);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        RST_N         = 1'b0;
        RUN           = 1'b0;
        IR_READY      = 1'b1;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 10'd0;
        default_mem();
        mem[5] = 10'b1001000010;

        // Reset state
        #2;
        check("rst_address", ADDRESS, 10'd0);
        check("rst_ir_out", IR_OUT, 10'd0);
        check("rst_pc_out", PC_OUT, 10'd0);
        check_bit("rst_ir_valid", IR_VALID, 1'b0);
        check_bit("rst_halted", HALTED, 1'b0);

        // Sequential fetch, JUMP at 5 back to 2, then stall
        release_and_run();
        check("start_address", ADDRESS, 10'd0);
        check_bit("start_valid", IR_VALID, 1'b0);
        push(0); push(1); push(2); push(3); push(4); push(5); push(2); push(3);
        tick(); check("seq_addr1", ADDRESS, 10'd1); check_bit("seq_valid1", IR_VALID, 1'b1);
        tick(); check("seq_addr2", ADDRESS, 10'd2);
        tick(); check("seq_addr3", ADDRESS, 10'd3);
        tick(); check("seq_addr4", ADDRESS, 10'd4);
        tick(); check("seq_addr5", ADDRESS, 10'd5);
        tick(); check("jump_addr", ADDRESS, 10'd2); check("jump_pc_out", PC_OUT, 10'd5);
        tick(); check("after_jump_addr", ADDRESS, 10'd3); check("after_jump_pc_out", PC_OUT, 10'd2);
        IR_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ir", IR_OUT, mem[2]);
            check("stall_pc_out", PC_OUT, 10'd2);
            check("stall_addr", ADDRESS, 10'd3);
            check_bit("stall_valid", IR_VALID, 1'b1);
        end
        IR_READY = 1'b1;
        tick(); check("resume_pc_out", PC_OUT, 10'd3); check("resume_addr", ADDRESS, 10'd4);
        tick();
        IR_READY = 1'b0;
        RST_N    = 1'b0;
        #1;
        check_bit("midrst_valid", IR_VALID, 1'b0);
        check("midrst_addr", ADDRESS, 10'd0);
        check("midrst_ir", IR_OUT, 10'd0);
        check("drain_a", 10'(exp_q.size()), 10'd0);

        // HALT at 7, then redirects out of HALT
        default_mem();
        mem[7]   = 10'b0000000000;
        IR_READY = 1'b1;
        release_and_run();
        for (int k = 0; k < 8; k++) push(k);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("halt_seq_addr", ADDRESS, (k < 8) ? 10'(k) : 10'd7);
        end
        check_bit("halt_captured_valid", IR_VALID, 1'b1);
        check_bit("halt_not_yet_halted", HALTED, 1'b0);
        tick();
        check_bit("halted_rise", HALTED, 1'b1);
        check_bit("halted_valid", IR_VALID, 1'b0);
        check("halted_addr", ADDRESS, 10'd7);
        tick();
        check_bit("halted_hold", HALTED, 1'b1);
        check("halted_addr_hold", ADDRESS, 10'd7);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 10'd6;
        tick();
        BRANCH_TAKEN = 1'b0;
        check("br_halt_addr", ADDRESS, 10'd6);
        check_bit("br_halt_valid", IR_VALID, 1'b0);
        check_bit("br_halt_cleared", HALTED, 1'b0);
        push(6);
        tick(); check("br_resume_addr", ADDRESS, 10'd7); check("br_resume_pc_out", PC_OUT, 10'd6);
        tick(); check("rehalt_addr", ADDRESS, 10'd7); check_bit("rehalt_valid", IR_VALID, 1'b1);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 10'd70;
        tick();
        BRANCH_TAKEN = 1'b0;
        check_bit("br_ready_flush", IR_VALID, 1'b0);
        check("br_mod_addr", ADDRESS, 10'd6);
        check_bit("br_ready_halted", HALTED, 1'b0);
        push(6);
        tick();
        check("br2_addr", ADDRESS, 10'd7);
        check("br2_pc_out", PC_OUT, 10'd6);
        check_bit("br2_valid", IR_VALID, 1'b1);
        tick();
        IR_READY = 1'b0;
        check("br2_halt_addr", ADDRESS, 10'd7);
        RST_N = 1'b0;
        #1;
        check_bit("rst_b_valid", IR_VALID, 1'b0);
        check("drain_b", 10'(exp_q.size()), 10'd0);

        // PC wrap from 63 to 0
        default_mem();
        mem[0]   = 10'b1001111110;
        IR_READY = 1'b1;
        release_and_run();
        push(0); push(62); push(63); push(0);
        tick(); check("wrap_jump_addr", ADDRESS, 10'd62);
        tick(); check("wrap_addr63", ADDRESS, 10'd63);
        tick(); check("wrap_addr0", ADDRESS, 10'd0); check("wrap_pc_out", PC_OUT, 10'd63);
        tick(); check("wrap_again", ADDRESS, 10'd62);
        tick(); check("wrap_end_addr", ADDRESS, 10'd63);
        IR_READY = 1'b0;
        RST_N    = 1'b0;
        #1;
        check("rst_c_addr", ADDRESS, 10'd0);
        check("drain_c", 10'(exp_q.size()), 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
